// File: rtl/imem_loader.sv
// imem_loader: byte-serial boot loader driving the instruction memory write port; define CHECKSUM_EN for a 32-bit sum trailer check
module imem_loader #(
    parameter int W     = 32,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [7:0]   i_byte,
    output logic         o_ready,
    output logic         o_WE,
    output logic [W-1:0] o_A,
    output logic [W-1:0] o_WD,
    output logic         o_cpu_rst,
    output logic         o_done,
    output logic         o_err
);
`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {LEN0, LEN1, DATA, CHECK, FIN, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {LEN0, LEN1, DATA, FIN, DONE, ERR} state_t;
`endif
    state_t       state_q, state_d;
    logic [15:0]  count_q, count_d;
    logic [1:0]   byte_q, byte_d;
    logic [23:0]  word_q, word_d;
    logic [W-1:0] idx_q, idx_d, a_q, a_d, wd_q, wd_d;
    logic         we_q, we_d;
    logic         accept, last_word;
    logic [31:0]  full;
    logic [15:0]  len;
`ifdef CHECKSUM_EN
    logic [31:0]  sum_q, sum_d;
`endif

    assign o_ready   = !(state_q inside {FIN, DONE, ERR});
    assign accept    = i_valid & o_ready;
    assign full      = {i_byte, word_q};
    assign len       = {i_byte, count_q[7:0]};
    assign last_word = (idx_q + 1'b1) == W'(count_q);
    assign o_WE      = we_q;
    assign o_A       = a_q;
    assign o_WD      = wd_q;
    assign o_done    = state_q == DONE;
    assign o_err     = state_q == ERR;
    assign o_cpu_rst = state_q != DONE;

    // Frame sequencing, little-endian word assembly and write-port staging
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        byte_d  = byte_q;
        word_d  = word_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        a_d     = a_q;
        wd_d    = wd_q;
`ifdef CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (state_q == FIN) state_d = DONE;
        if (accept) begin
            word_d = {i_byte, word_q[23:8]};
            case (state_q)
                LEN0: begin
                    count_d[7:0] = i_byte;
                    state_d      = LEN1;
                end
                LEN1: begin
                    count_d[15:8] = i_byte;
                    state_d       = (len == 16'd0) ? FIN : ({1'b0, len} > 17'(DEPTH)) ? ERR : DATA;
                end
                DATA: begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        we_d  = 1'b1;
                        a_d   = idx_q;
                        wd_d  = W'(full);
                        idx_d = idx_q + 1'b1;
`ifdef CHECKSUM_EN
                        sum_d = sum_q + full;
                        if (last_word) state_d = CHECK;
`else
                        if (last_word) state_d = FIN;
`endif
                    end
                end
`ifdef CHECKSUM_EN
                CHECK: begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) state_d = (full == sum_q) ? FIN : ERR;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= LEN0;
            count_q <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
`ifdef CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
`ifdef CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a frame-level reference model
module tb_imem_loader;
    localparam int W     = 32;
    localparam int DEPTH = 256;
`ifdef CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         i_rst, i_valid;
    logic [7:0]   i_byte;
    logic         o_ready, o_WE, o_cpu_rst, o_done, o_err;
    logic [W-1:0] o_A, o_WD;
    int           checks = 0, errors = 0, cyc = 0, done_c = -1;
    logic [7:0]   fr[$];
    logic [W-1:0] exp_a[$], exp_wd[$], obs_a[$], obs_wd[$];
    int           obs_c[$], acc_c[$];
    bit           exp_done, exp_err;

    imem_loader #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_byte(i_byte), .o_ready(o_ready),
        .o_WE(o_WE), .o_A(o_A), .o_WD(o_WD), .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write-port and completion monitor, cleared while reset is held
    always @(negedge clk) begin
        if (i_rst) begin
            obs_a.delete(); obs_wd.delete(); obs_c.delete(); done_c = -1;
        end else begin
            if (o_WE) begin obs_a.push_back(o_A); obs_wd.push_back(o_WD); obs_c.push_back(cyc); end
            if (o_done && done_c < 0) done_c = cyc;
        end
    end

    // reference: the writes and final outcome a frame must produce
    function automatic void model();
        int cnt, n;
        logic [31:0] w, sum;
        exp_a.delete(); exp_wd.delete(); exp_done = 0; exp_err = 0; sum = 0;
        cnt = int'({fr[1], fr[0]});
        if (cnt > DEPTH) begin exp_err = 1; return; end
        if (cnt == 0) begin exp_done = 1; return; end
        for (int k = 0; k < cnt && fr.size() >= 6 + 4 * k; k++) begin
            w = {fr[5 + 4 * k], fr[4 + 4 * k], fr[3 + 4 * k], fr[2 + 4 * k]};
            exp_a.push_back(W'(k)); exp_wd.push_back(W'(w)); sum += w;
        end
        n = 2 + 4 * cnt;
        if (fr.size() < n + (CK ? 4 : 0)) return;
        if (CK) begin
            w = {fr[n + 3], fr[n + 2], fr[n + 1], fr[n]};
            exp_err = w != sum; exp_done = !exp_err;
        end else exp_done = 1;
    endfunction

    task automatic mk_frame(input int cnt, input bit good);
        logic [31:0] w, s;
        s = 0; fr.delete();
        fr.push_back(8'(cnt)); fr.push_back(8'(cnt >> 8));
        for (int k = 0; k < cnt; k++) begin
            w = $urandom; s += w;
            for (int b = 0; b < 4; b++) fr.push_back(w[8 * b +: 8]);
        end
        if (CK) begin
            if (!good) s = ~s;
            for (int b = 0; b < 4; b++) fr.push_back(s[8 * b +: 8]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); i_rst = 1; i_valid = 0; i_byte = 0;
        repeat (2) @(negedge clk);
        i_rst = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        n = gap_max > 0 ? $urandom_range(gap_max, 0) : 0;
        repeat (n) begin i_valid = 0; i_byte = 8'($urandom); @(negedge clk); end
        i_valid = 1; i_byte = b;
        for (int t = 0; t < 20 && !o_ready; t++) @(negedge clk);
        checks++;
        if (!o_ready) begin errors++; $display("FAIL ready_timeout: o_ready=%b required 1", o_ready); end
        @(negedge clk); acc_c.push_back(cyc); i_valid = 0;
    endtask

    task automatic send_frame(input int gap_max);
        acc_c.delete();
        foreach (fr[i]) send_byte(fr[i], gap_max);
    endtask

    task automatic wait_end();
        for (int t = 0; t < 20 && !(o_done || o_err); t++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); i_rst = 1; i_valid = 1; i_byte = 8'h5A;
        repeat (2) @(negedge clk);
        checks += 6;
        if (o_cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst: got %b want 1", o_cpu_rst); end
        if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", o_ready); end
        if (o_WE !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", o_WE); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", o_done); end
        if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_err); end
        if (o_A !== '0 || o_WD !== '0) begin errors++; $display("FAIL rst_port: A=%h WD=%h want 0", o_A, o_WD); end
        i_rst = 0; i_valid = 0;
    endtask

    task automatic test_back_to_back();
        int last;
        do_reset();
        fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CK) begin fr.push_back(8'h67); fr.push_back(8'h15); fr.push_back(8'hE2); fr.push_back(8'hF0); end
        model(); send_frame(0); wait_end();
        checks += 4;
        if (obs_a.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", obs_a.size()); end
        else begin
            for (int k = 0; k < 2; k++) begin
                checks += 2;
                if (obs_a[k] !== exp_a[k] || obs_wd[k] !== exp_wd[k]) begin
                    errors++; $display("FAIL b2b_write%0d: got A=%h WD=%h want A=%h WD=%h", k, obs_a[k], obs_wd[k], exp_a[k], exp_wd[k]);
                end
                if (obs_c[k] != acc_c[5 + 4 * k]) begin
                    errors++; $display("FAIL b2b_timing%0d: pulse cycle %0d want %0d", k, obs_c[k], acc_c[5 + 4 * k]);
                end
            end
        end
        last = acc_c[acc_c.size() - 1];
        if (o_done !== 1'b1 || o_cpu_rst !== 1'b0) begin errors++; $display("FAIL b2b_done: done=%b cpu_rst=%b want 1/0", o_done, o_cpu_rst); end
        if (o_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", o_err); end
        if (done_c <= last || done_c > last + 2) begin errors++; $display("FAIL b2b_done_time: cycle %0d want %0d..%0d", done_c, last + 1, last + 2); end
    endtask

    task automatic test_gaps();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            if (it == 0) begin
                fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
                if (CK) begin fr.push_back(8'h67); fr.push_back(8'h15); fr.push_back(8'hE2); fr.push_back(8'hF0); end
            end else mk_frame($urandom_range(5, 1), 1'b1);
            model(); send_frame(3); wait_end();
            checks += 3;
            if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL gaps_count%0d: got %0d want %0d", it, obs_a.size(), exp_a.size()); end
            else foreach (exp_a[k]) if (obs_a[k] !== exp_a[k] || obs_wd[k] !== exp_wd[k]) begin
                errors++; $display("FAIL gaps_write%0d_%0d: got A=%h WD=%h want A=%h WD=%h", it, k, obs_a[k], obs_wd[k], exp_a[k], exp_wd[k]);
            end
            if (o_done !== exp_done || o_err !== exp_err) begin errors++; $display("FAIL gaps_end%0d: done=%b err=%b want %b/%b", it, o_done, o_err, exp_done, exp_err); end
            if (o_ready !== 1'b0) begin errors++; $display("FAIL gaps_ready%0d: got %b want 0", it, o_ready); end
        end
    endtask

    task automatic test_len_err();
        do_reset();
        fr = '{8'h01, 8'h01};
        model(); send_frame(1);
        for (int t = 0; t < 8; t++) begin i_valid = 1; i_byte = 8'($urandom); @(negedge clk); end
        i_valid = 0;
        checks += 5;
        if (o_err !== exp_err) begin errors++; $display("FAIL lenerr_err: got %b want %b", o_err, exp_err); end
        if (o_ready !== 1'b0) begin errors++; $display("FAIL lenerr_ready: got %b want 0", o_ready); end
        if (o_cpu_rst !== 1'b1) begin errors++; $display("FAIL lenerr_cpu_rst: got %b want 1", o_cpu_rst); end
        if (o_done !== 1'b0) begin errors++; $display("FAIL lenerr_done: got %b want 0", o_done); end
        if (obs_a.size() != 0) begin errors++; $display("FAIL lenerr_writes: got %0d want 0", obs_a.size()); end
    endtask

    task automatic test_midword_reset();
        do_reset();
        fr = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_frame(1);
        i_rst = 1; @(negedge clk); i_rst = 0;
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        if (CK) begin fr.push_back(8'hAA); fr.push_back(8'hBB); fr.push_back(8'hCC); fr.push_back(8'hDD); end
        model(); send_frame(2); wait_end();
        checks += 2;
        if (obs_a.size() != 1 || obs_a[0] !== exp_a[0] || obs_wd[0] !== exp_wd[0]) begin
            errors++; $display("FAIL midrst_write: got %0d writes first A=%h WD=%h want 1 A=%h WD=%h", obs_a.size(), obs_a.size() ? obs_a[0] : 'x, obs_wd.size() ? obs_wd[0] : 'x, exp_a[0], exp_wd[0]);
        end
        if (o_done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", o_done); end
    endtask

    task automatic test_zero_count();
        do_reset();
        fr = '{8'h00, 8'h00};
        model(); send_frame(0); wait_end();
        checks += 2;
        if (o_done !== exp_done || o_err !== exp_err) begin errors++; $display("FAIL zero_end: done=%b err=%b want %b/%b", o_done, o_err, exp_done, exp_err); end
        if (obs_a.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", obs_a.size()); end
    endtask

    task automatic test_max_count();
        int bad = 0;
        do_reset();
        mk_frame(DEPTH, 1'b1);
        model(); send_frame(0); wait_end();
        checks += 3;
        if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL max_count: got %0d want %0d", obs_a.size(), exp_a.size()); end
        else begin
            foreach (exp_a[k]) if (obs_a[k] !== exp_a[k] || obs_wd[k] !== exp_wd[k]) bad++;
            if (bad != 0 || obs_a[DEPTH - 1] !== W'(DEPTH - 1)) begin errors++; $display("FAIL max_writes: %0d wrong, last A=%h want %h", bad, obs_a[DEPTH - 1], DEPTH - 1); end
        end
        if (o_done !== exp_done || o_err !== exp_err) begin errors++; $display("FAIL max_end: done=%b err=%b want %b/%b", o_done, o_err, exp_done, exp_err); end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
        model(); send_frame(1); wait_end();
        checks += 3;
        if (o_err !== exp_err || o_done !== exp_done) begin errors++; $display("FAIL ck_bad: err=%b done=%b want %b/%b", o_err, o_done, exp_err, exp_done); end
        if (obs_a.size() != 2) begin errors++; $display("FAIL ck_writes: got %0d want 2", obs_a.size()); end
        if (o_cpu_rst !== 1'b1) begin errors++; $display("FAIL ck_cpu_rst: got %b want 1", o_cpu_rst); end
        for (int it = 0; it < 2; it++) begin
            do_reset();
            mk_frame($urandom_range(4, 1), it[0]);
            model(); send_frame(2); wait_end();
            checks++;
            if (o_err !== exp_err || o_done !== exp_done) begin errors++; $display("FAIL ck_rand%0d: err=%b done=%b want %b/%b", it, o_err, o_done, exp_err, exp_done); end
        end
    endtask
`endif

    initial begin
        i_rst = 1; i_valid = 0; i_byte = 0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_len_err();
        test_midword_reset();
        test_zero_count();
        test_max_count();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
